// File: rtl/register_file_if.sv
// Operand-read / writeback bus between the register file and its datapath neighbours.
// The master side is decode/writeback; the slave side is the register file itself.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, wr_data, reg_write,
    input  data1, data2
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, wr_data, reg_write,
    output data1, data2
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with same-cycle
// writeback bypass, one synchronous write port, r0 hardwired to zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  register_file_if.slave       bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Flop array rather than RAM so every entry clears asynchronously.
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic write_en;
  assign write_en = bus.reg_write && (bus.rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[bus.rd_addr] <= bus.wr_data;
    end
  end

  // Priority: zero register > bypass > stored value. Reset forces zero so a
  // write held up by reset never leaks through the bypass path.
  always_comb begin
    bus.data1 = '0;
    if (rst_n && (bus.rs1_addr != '0)) begin
      if (bus.reg_write && (bus.rd_addr == bus.rs1_addr)) begin
        bus.data1 = bus.wr_data;
      end else begin
        bus.data1 = regs[bus.rs1_addr];
      end
    end
  end

  always_comb begin
    bus.data2 = '0;
    if (rst_n && (bus.rs2_addr != '0)) begin
      if (bus.reg_write && (bus.rd_addr == bus.rs2_addr)) begin
        bus.data2 = bus.wr_data;
      end else begin
        bus.data2 = regs[bus.rs2_addr];
      end
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected operands into a
// scoreboard queue, an independent monitor pops and compares them.
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    bit              chk1;
    logic [DW-1:0]   exp1;
    bit              chk2;
    logic [DW-1:0]   exp2;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Monitor: compares the live operand outputs whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() > 0);
      e = exp_q[0];
      if (e.chk1) begin
        total++;
        if (bus.data1 === e.exp1) passed++;
        else $display("FAIL %s data1: got %h expected %h", e.name, bus.data1, e.exp1);
      end
      if (e.chk2) begin
        total++;
        if (bus.data2 === e.exp2) passed++;
        else $display("FAIL %s data2: got %h expected %h", e.name, bus.data2, e.exp2);
      end
      void'(exp_q.pop_front());
    end
  end

  task automatic expect_ops(input string name, input bit c1, input logic [DW-1:0] e1,
                            input bit c2, input logic [DW-1:0] e2);
    exp_t e;
    #1;
    e.name = name; e.chk1 = c1; e.exp1 = e1; e.chk2 = c2; e.exp2 = e2;
    exp_q.push_back(e);
    fork
      wait (exp_q.size() == 0);
      begin
        #100;
        total++;
        $display("FAIL %s: monitor did not consume expectation", name);
        exp_q.delete();
      end
    join_any
    disable fork;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bus.reg_write = we;
    bus.rd_addr   = rd;
    bus.wr_data   = wd;
    bus.rs1_addr  = r1;
    bus.rs2_addr  = r2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, '0, 5'd5, 5'd9);
    expect_ops("reset_held", 1, 32'd0, 1, 32'd0);
    #12 rst_n = 1'b1;
    tick();

    // Async reset mid-cycle clears storage with no clock edge.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    tick();
    drive(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    expect_ops("r5_written", 1, 32'hDEADBEEF, 0, '0);
    rst_n = 1'b0;
    expect_ops("async_clear", 1, 32'd0, 0, '0);
    rst_n = 1'b1;
    expect_ops("after_release", 1, 32'd0, 0, '0);

    // Write pending across an edge while reset is low must be dropped.
    rst_n = 1'b0;
    drive(1'b1, 5'd6, 32'h000000AA, 5'd5, 5'd6);
    expect_ops("reset_no_bypass", 0, '0, 1, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd6, 32'h000000AA, 5'd5, 5'd6);
    expect_ops("reset_write_ignored", 0, '0, 1, 32'd0);

    // Basic write/read.
    drive(1'b1, 5'd3, 32'd4, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 32'd3, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd7, 32'd3, 5'd3, 5'd7);
    expect_ops("write_read", 1, 32'd4, 1, 32'd3);

    // Zero register, including during the write cycle.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    expect_ops("r0_during_write", 1, 32'd0, 1, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    expect_ops("r0_after_write", 1, 32'd0, 1, 32'd0);

    // Bypass.
    drive(1'b1, 5'd9, 32'd1, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'd2, 5'd9, 5'd9);
    expect_ops("bypass_before_edge", 1, 32'd2, 1, 32'd2);
    tick();
    drive(1'b0, 5'd9, 32'd2, 5'd9, 5'd9);
    expect_ops("bypass_after_edge", 1, 32'd2, 1, 32'd2);
    drive(1'b1, 5'd3, 32'd5, 5'd9, 5'd3);
    expect_ops("bypass_one_port", 1, 32'd2, 1, 32'd5);
    drive(1'b0, 5'd3, 32'd5, 5'd9, 5'd3);
    expect_ops("bypass_withdrawn", 1, 32'd2, 1, 32'd4);

    // Write disabled.
    drive(1'b0, 5'd4, 32'h12345678, 5'd0, 5'd4);
    expect_ops("wr_disabled_no_bypass", 0, '0, 1, 32'd0);
    tick();
    expect_ops("wr_disabled", 0, '0, 1, 32'd0);

    // Full sweep.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, AW'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, '0, AW'(i), AW'(31 - i));
      expect_ops($sformatf("sweep_%0d", i), 1, 32'(i) * 32'h01010101,
                 1, 32'(31 - i) * 32'h01010101);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end
endmodule
